chacha_xor_stream: RTL and testbench

- Downstream consumer of the ChaCha block datapath's serialized 8-bit keystream; XORs it byte-by-byte with a plaintext/ciphertext stream.
- Buffers keystream in a FIFO, requests new blocks from the core controller, and issues incrementing 32-bit block counter values.
- Exposes valid/ready handshakes on the data input and output.
- Encryption and decryption are the same operation.

---
 rtl/chacha_xor_stream.sv | 160 ++++++++++++++++
 tb/tb_chacha_xor_stream.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_xor_stream.sv
// Keystream consumer for the ChaCha block core: buffers serialized keystream
// bytes, requests blocks with incrementing counters and XORs them onto a byte stream.
module chacha_xor_stream #(
  parameter int KS_DEPTH    = 128,
  parameter int BLOCK_BYTES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] counter_init_i,
  output logic        block_req_o,
  output logic [31:0] block_counter_o,
  input  logic        block_ack_i,
  input  logic        ks_valid_i,
  input  logic [7:0]  ks_data_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        done_o,
  output logic        ks_overflow_o,
  output logic        counter_wrap_o
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(KS_DEPTH);
  localparam logic [AW:0] BLOCK_W = (AW+1)'(BLOCK_BYTES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state;
  logic [7:0]    ks_mem [0:KS_DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ks_count;
  logic [AW:0]   ks_free;
  logic          in_flight;
  logic [5:0]    arr_cnt;
  logic [31:0]   blk_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          hs;

  assign ks_free         = DEPTH_W - ks_count;
  assign fifo_full       = (ks_count == DEPTH_W);
  assign fifo_empty      = (ks_count == '0);
  assign block_req_o     = (state == RUN) && !in_flight && (ks_free >= BLOCK_W);
  assign block_counter_o = blk_cnt;
  assign in_ready_o      = (state == RUN) && !fifo_empty && (!out_valid_o || out_ready_i);
  assign hs              = in_valid_i && in_ready_o;
  assign pop             = hs;
  assign push            = (state == RUN) && ks_valid_i && !fifo_full;

  // Read is combinational so the popped byte lands in the output register
  // on the handshake edge, keeping a one-cycle, full-throughput datapath.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ks_mem[wr_ptr] <= ks_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ks_count       <= '0;
      in_flight      <= 1'b0;
      arr_cnt        <= '0;
      blk_cnt        <= '0;
      out_valid_o    <= 1'b0;
      out_data_o     <= '0;
      out_last_o     <= 1'b0;
      done_o         <= 1'b0;
      ks_overflow_o  <= 1'b0;
      counter_wrap_o <= 1'b0;
    end else begin
      done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            blk_cnt        <= counter_init_i;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ks_count       <= '0;
            ks_overflow_o  <= 1'b0;
            counter_wrap_o <= 1'b0;
            state          <= RUN;
          end
        end

        RUN: begin
          if (block_req_o && block_ack_i) begin
            in_flight <= 1'b1;
            arr_cnt   <= '0;
            blk_cnt   <= blk_cnt + 32'd1;
            if (blk_cnt == '1) begin
              counter_wrap_o <= 1'b1;
            end
          end
          if (ks_valid_i && fifo_full) begin
            ks_overflow_o <= 1'b1;
          end
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          if (push && !pop) begin
            ks_count <= ks_count + 1'b1;
          end else if (pop && !push) begin
            ks_count <= ks_count - 1'b1;
          end
          if (hs && in_last_i) begin
            state <= FLUSH;
          end
        end

        FLUSH: begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          ks_count <= '0;
          if (!in_flight && fifo_empty && !out_valid_o) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Arrivals are counted in every state so a flushed block still retires.
      if (in_flight && ks_valid_i) begin
        arr_cnt <= arr_cnt + 6'd1;
        if (arr_cnt == 6'd63) begin
          in_flight <= 1'b0;
        end
      end

      if (hs) begin
        out_data_o  <= in_data_i ^ ks_mem[rd_ptr];
        out_last_o  <= in_last_i;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Directed bench for chacha_xor_stream with a behavioural ChaCha core that
// answers block requests with a counter-derived keystream.
module tb_chacha_xor_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] counter_init = '0;
  logic        block_req;
  logic [31:0] block_counter;
  logic        block_ack;
  logic        ks_valid;
  logic [7:0]  ks_data;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        done;
  logic        ks_overflow;
  logic        counter_wrap;

  int total = 0;
  int bad = 0;

  // core model state (written only by the core process)
  int          core_sent = 0;
  int          core_left = 0;
  int          core_idx = 0;
  int          ack_n = 0;
  int          inject_served = 0;
  logic [31:0] core_ctr = '0;
  logic [31:0] ack_ctr [64];
  bit          gap_ph = 1'b0;
  // core controls (written only by the main process)
  bit          core_gap = 1'b0;
  int          inject_cnt = 0;

  chacha_xor_stream dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (start),
    .counter_init_i (counter_init),
    .block_req_o    (block_req),
    .block_counter_o(block_counter),
    .block_ack_i    (block_ack),
    .ks_valid_i     (ks_valid),
    .ks_data_i      (ks_data),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_last_i      (in_last),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_last_o     (out_last),
    .out_ready_i    (out_ready),
    .done_o         (done),
    .ks_overflow_o  (ks_overflow),
    .counter_wrap_o (counter_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ks_of(input logic [31:0] c, input int i);
    logic [5:0] lo;
    lo = i[5:0];
    return {c[1:0] - 2'd1, lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: acks a request, then streams 64 bytes (optionally every other cycle).
  initial begin
    block_ack = 1'b0;
    ks_valid  = 1'b0;
    ks_data   = '0;
    forever begin
      @(negedge clk);
      block_ack = 1'b0;
      ks_valid  = 1'b0;
      if (!rst_n) begin
        core_left = 0;
      end else if (core_left > 0) begin
        gap_ph = !gap_ph;
        if (!core_gap || gap_ph) begin
          ks_valid = 1'b1;
          ks_data  = ks_of(core_ctr, core_idx);
          core_idx++;
          core_left--;
          core_sent++;
        end
      end else if (block_req) begin
        block_ack = 1'b1;
        core_ctr  = block_counter;
        if (ack_n < 64) ack_ctr[ack_n] = core_ctr;
        ack_n++;
        core_left = 64;
        core_idx  = 0;
      end else if (inject_served != inject_cnt) begin
        ks_valid = 1'b1;
        ks_data  = 8'h5A;
        inject_served++;
        core_sent++;
      end
    end
  end

  task automatic run_msg(input logic [31:0] ctr0, input int nbytes, input logic [7:0] seed,
                         input bit rnd_ready, input int exp_acks);
    logic [7:0] exp_q [$];
    logic [7:0] held = '0;
    logic [7:0] expv;
    bit stalled = 1'b0;
    bit hs_prev = 1'b0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int sent_base;
    int ack_base;
    int occ;
    int dn = 0;
    int wc = 0;
    int left_at = -1;

    @(negedge clk);
    start = 1'b1;
    counter_init = ctr0;
    sent_base = core_sent;
    ack_base = ack_n;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("start_req", 32'(block_req), 32'd1);
    chk("start_ctr", block_counter, ctr0);
    chk("start_ovf_clr", 32'(ks_overflow), 32'd0);
    chk("start_wrap_clr", 32'(counter_wrap), 32'd0);

    while (got < nbytes && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < nbytes) begin
        in_valid = 1'b1;
        in_data  = 8'(int'(seed) + sent * 37);
        in_last  = (sent == nbytes - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #2;
      if (hs_prev) chk("latency1", 32'(out_valid), 32'd1);
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", 32'd1, 32'd0);
        end else begin
          expv = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(expv));
          chk("out_last", 32'(out_last), 32'(got == nbytes - 1));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (stalled) chk("stall_ready", 32'(in_ready), 32'd0);
      occ = core_sent - sent_base - (ks_valid ? 1 : 0) - sent;
      if (block_req) chk("req_space", 32'(128 - occ >= 64), 32'd1);
      hs_prev = in_valid && in_ready;
      if (hs_prev) begin
        exp_q.push_back(in_data ^ ks_of(ctr0 + 32'(sent / 64), sent % 64));
        sent++;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("msg_complete", 32'(got), 32'(nbytes));

    while (dn == 0 && wc < 400) begin
      @(negedge clk);
      #2;
      wc++;
      if (done) begin
        dn = 1;
        left_at = core_left;
      end
    end
    chk("done_seen", 32'(dn), 32'd1);
    chk("done_after_ks", 32'(left_at), 32'd0);
    @(negedge clk);
    #2;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_noreq", 32'(block_req), 32'd0);
    if (exp_acks > 0) chk("ack_count", 32'(ack_n - ack_base), 32'(exp_acks));
    for (int k = 0; k < ack_n - ack_base && ack_base + k < 64; k++) begin
      chk("ack_ctr", ack_ctr[ack_base + k], ctr0 + 32'(k));
    end
    $display("msg ctr=0x%08h bytes=%0d acks=%0d cycles=%0d", ctr0, nbytes, ack_n - ack_base, cyc);
  endtask

  initial begin
    int base;
    int ab;
    int wc;

    // reset state
    #2;
    chk("rst_req", 32'(block_req), 32'd0);
    chk("rst_ctr", block_counter, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ks_overflow), 32'd0);
    chk("rst_wrap", 32'(counter_wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single byte: 0xAA ^ ks 0x00 = 0xAA with last
    run_msg(32'h0000_0001, 1, 8'hAA, 1'b0, 1);
    // streaming at full rate: counters 0..3
    run_msg(32'h0000_0000, 200, 8'h03, 1'b0, 4);
    // random backpressure
    run_msg(32'h0000_0040, 150, 8'h51, 1'b1, 0);
    // counter wrap: 0xFFFFFFFF then 0
    run_msg(32'hFFFF_FFFF, 100, 8'h77, 1'b0, 2);
    chk("wrap_sticky", 32'(counter_wrap), 32'd1);
    // flush mid-block with a slow core
    core_gap = 1'b1;
    run_msg(32'h0000_0010, 11, 8'h21, 1'b0, 1);
    core_gap = 1'b0;
    // clean FIFO after flush
    run_msg(32'h0000_0025, 3, 8'h9C, 1'b0, 1);

    // overflow: fill 128 bytes with no consumption, then inject one more
    base = core_sent;
    ab = ack_n;
    @(negedge clk);
    start = 1'b1;
    counter_init = 32'h0000_0008;
    @(negedge clk);
    start = 1'b0;
    wc = 0;
    while (!((core_sent - base) == 128 && core_left == 0) && wc < 500) begin
      @(negedge clk);
      wc++;
    end
    @(negedge clk);
    #2;
    chk("fill_done", 32'(core_sent - base), 32'd128);
    chk("full_noreq", 32'(block_req), 32'd0);
    chk("fill_acks", 32'(ack_n - ab), 32'd2);
    chk("fill_no_ovf", 32'(ks_overflow), 32'd0);
    inject_cnt++;
    repeat (3) @(negedge clk);
    #2;
    chk("ovf_set", 32'(ks_overflow), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("ovf_sticky", 32'(ks_overflow), 32'd1);
    $display("overflow ctr=0x00000008 injected=1 ovf=%0d", ks_overflow);

    // park an output byte under backpressure, then reset asynchronously
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h11;
    out_ready = 1'b0;
    #2;
    chk("park_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("park_valid", 32'(out_valid), 32'd1);
    chk("park_data", 32'(out_data), 32'h0000_00D1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_req", 32'(block_req), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_ovf", 32'(ks_overflow), 32'd0);
    chk("arst_ctr", block_counter, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    $display("reset mid-run applied");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    // start accepted after reset release
    run_msg(32'h0000_0030, 5, 8'h44, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
